// File: rtl/alu_slice_sequencer_if.sv
// Request/result handshake bundle for the bit-serial-by-slice ALU sequencer.
// The master side issues an operation and consumes the result; the slave side
// is the sequencer itself.
interface alu_slice_sequencer_if #(
   parameter int DW = 32
);
   logic          start_valid;
   logic          start_ready;
   logic [3:0]    opcode;
   logic [DW-1:0] a_in;
   logic [DW-1:0] b_in;
   logic          c_in;
   logic          v_in;
   logic [DW-1:0] result;
   logic [3:0]    flags;
   logic          no_write;
   logic          done_valid;
   logic          done_ready;

   modport master (
      output start_valid, opcode, a_in, b_in, c_in, v_in, done_ready,
      input  start_ready, result, flags, no_write, done_valid
   );

   modport slave (
      input  start_valid, opcode, a_in, b_in, c_in, v_in, done_ready,
      output start_ready, result, flags, no_write, done_valid
   );
endinterface

// File: rtl/alu_slice_sequencer.sv
// ARM data-processing ALU that evaluates a DW-bit operation SW bits per cycle,
// least significant slice first, chaining the adder carry between slices.
// Operands are captured on the accepting edge, so bus inputs may change freely
// while an operation is in flight.
module alu_slice_sequencer #(
   parameter int DW = 32,
   parameter int SW = 8
) (
   input logic                  clk,
   input logic                  reset_n,
   alu_slice_sequencer_if.slave bus
);
   localparam int SW_SAFE = (SW < 1) ? 1 : SW;
   localparam int NSLICE  = DW / SW_SAFE;
   localparam int CW      = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   if ((SW < 1) || ((DW % SW_SAFE) != 0)) begin : g_bad_slice
      $error("alu_slice_sequencer: DW must be a positive multiple of SW");
   end

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Logical ops leave C and V as they were; everything else goes through the adder.
   function automatic logic is_logical(input logic [3:0] o);
      return (o == OP_AND) || (o == OP_EOR) || (o == OP_TST) || (o == OP_TEQ) ||
             (o == OP_ORR) || (o == OP_MOV) || (o == OP_BIC) || (o == OP_MVN);
   endfunction

   // Reverse subtracts exchange Rn and Op2 before any inversion.
   function automatic logic swaps_operands(input logic [3:0] o);
      return (o == OP_RSB) || (o == OP_RSC);
   endfunction

   // Subtraction is A + ~B + carry; BIC and MVN need ~B for their logic function.
   function automatic logic inverts_b(input logic [3:0] o);
      return (o == OP_SUB) || (o == OP_RSB) || (o == OP_SBC) || (o == OP_RSC) ||
             (o == OP_CMP) || (o == OP_BIC) || (o == OP_MVN);
   endfunction

   function automatic logic initial_carry(input logic [3:0] o, input logic c);
      logic ci;
      ci = 1'b0;
      if ((o == OP_SUB) || (o == OP_RSB) || (o == OP_CMP)) ci = 1'b1;
      else if ((o == OP_ADC) || (o == OP_SBC) || (o == OP_RSC)) ci = c;
      return ci;
   endfunction

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic [3:0]    op;
   logic [DW-1:0] a_op, b_op;
   logic          carry, c_cap, v_cap, zero_acc;
   logic [DW-1:0] res;
   logic [3:0]    flg;
   logic          nw;

   logic [SW-1:0] sa, sb, sres;
   logic [SW:0]   sum;
   logic          c_msb;
   logic          last;
   logic          swap, inv;
   logic [DW-1:0] cap_a, cap_b, res_ins;

   // Slice datapath: current slice of both operands through the selected function.
   always_comb begin
      sa    = a_op[SW-1:0];
      sb    = b_op[SW-1:0];
      sum   = {1'b0, sa} + {1'b0, sb} + {{SW{1'b0}}, carry};
      c_msb = sum[SW-1] ^ sa[SW-1] ^ sb[SW-1];
      case (op)
         OP_AND, OP_TST, OP_BIC: sres = sa & sb;
         OP_EOR, OP_TEQ:         sres = sa ^ sb;
         OP_ORR:                 sres = sa | sb;
         OP_MOV, OP_MVN:         sres = sb;
         default:                sres = sum[SW-1:0];
      endcase
      last    = (cnt == CW'(NSLICE - 1));
      res_ins = '0;
      res_ins[SW-1:0] = sres;
      swap  = swaps_operands(bus.opcode);
      inv   = inverts_b(bus.opcode);
      cap_a = swap ? bus.b_in : bus.a_in;
      cap_b = (swap ? bus.a_in : bus.b_in) ^ {DW{inv}};
   end

   // State register; reset wins over any pending request.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next      = state;
      bus.start_ready = 1'b0;
      bus.done_valid  = 1'b0;
      case (state)
         IDLE: begin
            bus.start_ready = 1'b1;
            if (bus.start_valid) state_next = RUN;
         end
         RUN: begin
            if (last) state_next = DONE;
         end
         DONE: begin
            bus.done_valid = 1'b1;
            if (bus.done_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, per-slice evaluation and flag formation on the last slice.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
         res <= '0;
         flg <= '0;
         nw  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_valid) begin
                  op       <= bus.opcode;
                  a_op     <= cap_a;
                  b_op     <= cap_b;
                  carry    <= initial_carry(bus.opcode, bus.c_in);
                  c_cap    <= bus.c_in;
                  v_cap    <= bus.v_in;
                  zero_acc <= 1'b1;
                  cnt      <= '0;
                  nw       <= (bus.opcode[3:2] == 2'b10);
               end
            end
            RUN: begin
               a_op     <= a_op >> SW;
               b_op     <= b_op >> SW;
               res      <= (res >> SW) | (res_ins << (DW - SW));
               carry    <= sum[SW];
               zero_acc <= zero_acc & (sres == '0);
               cnt      <= cnt + CW'(1);
               if (last) begin
                  flg[3] <= sres[SW-1];
                  flg[2] <= zero_acc & (sres == '0);
                  flg[1] <= is_logical(op) ? c_cap : sum[SW];
                  flg[0] <= is_logical(op) ? v_cap : (c_msb ^ sum[SW]);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result   = res;
   assign bus.flags    = flg;
   assign bus.no_write = nw;
endmodule
